apb_master_bridge: RTL and testbench
====================================

Name: apb_master_bridge

Overview:
APB4 requester that converts a simple valid/ready command interface into single APB transfers (IDLE -> SETUP -> ACCESS) and returns a one-cycle response pulse carrying read data and error status. It sits between an internal controller (CPU shim, DMA, test sequencer) and an APB bus of register slaves. A programmable ACCESS-phase watchdog aborts transfers to slaves that never assert pready.

Parameters:
ADDR_WIDTH, 32, width of cmd_addr and paddr
DATA_WIDTH, 32, width of write/read data; must be 8, 16 or 32
TIMEOUT_CYCLES, 16, maximum ACCESS cycles with pready low before abort; 0 disables the watchdog

Ports:
pclk  in  1  clock, all logic on rising edge
preset  in  1  synchronous reset, active high
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_WIDTH  byte address
cmd_wdata  in  DATA_WIDTH  write data
cmd_strb  in  DATA_WIDTH/8  write byte strobes
cmd_prot  in  3  protection attributes
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and timeouts
rsp_err  out  1  pslverr sampled, or timeout
rsp_timeout  out  1  transfer aborted by watchdog
paddr  out  ADDR_WIDTH  APB address
pprot  out  3  APB protection
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
pwdata  out  DATA_WIDTH  APB write data
pstrb  out  DATA_WIDTH/8  APB strobes
pready  in  1  slave ready
prdata  in  DATA_WIDTH  slave read data
pslverr  in  1  slave error

Behaviour:
- Reset (sync, preset=1 at rising edge): state IDLE; psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout = 0; paddr, pprot, pwdata, pstrb, rsp_rdata = 0; watchdog counter = 0. Reset mid-transfer: bus returns to IDLE on the next edge, no response is generated, and the aborted command is lost.
- FSM states are IDLE, SETUP and ACCESS.
- IDLE: cmd_ready=1; psel=penable=0; APB address/data outputs driven 0. On cmd_valid, register the command and go to SETUP.
- SETUP (exactly one cycle): psel=1, penable=0, paddr/pprot/pwrite/pwdata/pstrb drive the registered command. For reads, pwdata=0 and pstrb=0. Next state is ACCESS.
- ACCESS: psel=1, penable=1, all address/control/data outputs held stable. Completion occurs at the edge where pready=1. At completion, sample prdata (reads only) and pslverr, then go to IDLE with rsp_valid=1 for that one cycle.
- cmd_ready=0 in SETUP and ACCESS. In the IDLE cycle carrying rsp_valid, cmd_ready=1, so the next command can be accepted there. Minimum throughput is one transfer per 3 cycles with a zero-wait slave.
- Latency: command accepted at edge N, SETUP during N..N+1, ACCESS from N+1, zero-wait completion at edge N+2, rsp_valid high in the cycle after edge N+2.
- Watchdog: the counter clears on entering ACCESS and increments each ACCESS cycle with pready=0. If it reaches TIMEOUT_CYCLES (nonzero), abort: go to IDLE and drop psel/penable. The response is rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0. If pready=1 arrives on the same edge the count reaches the limit, the transfer completes normally (pready wins).
- rsp_rdata, rsp_err and rsp_timeout are valid only while rsp_valid=1. They are 0 in all other cycles.
- rsp_err = pslverr sampled at completion, for both reads and writes. On a read error, rsp_rdata still returns the sampled prdata.
- There is no response back-pressure: the consumer must accept rsp_valid when it is asserted.
- Commands presented while cmd_ready=0 are ignored; the requester must hold them.

Test Plan:
- Zero-wait bench slave (pready=penable); write addr 0x0C, data 0xDEADBEEF, strb 0xF -> cmd_ready low 2 cycles; psel high 2 cycles, penable 1 cycle, pwrite=1, paddr=0x0C; rsp_valid 3 cycles after acceptance, rsp_err=0, rsp_rdata=0.
- Read back 0x0C -> SETUP shows pstrb=0 and pwdata=0; rsp_rdata=0xDEADBEEF, rsp_err=0.
- Slave inserts 3 wait states on read of 0x10 returning 0x12345678 -> ACCESS lasts 4 cycles with paddr/pwrite stable; rsp_rdata=0x12345678.
- Slave asserts pslverr with pready on write to 0x04 -> rsp_err=1, rsp_timeout=0. Separately, slave holds pready=0 with TIMEOUT_CYCLES=16 -> abort after 16 ACCESS cycles; rsp_err=1, rsp_timeout=1, rsp_rdata=0; psel=0 the cycle after abort.
- Back-to-back: cmd_valid held high with 4 queued reads -> a new SETUP every 3 cycles; each acceptance coincides with the previous rsp_valid; no command dropped.
- Assert preset during ACCESS of a write -> next cycle psel=penable=0, rsp_valid never asserts; a subsequent command completes normally.

Source files
------------

// File: rtl/apb_master_bridge.sv
// APB4 requester: turns a valid/ready command into a single SETUP/ACCESS transfer
// and returns a one-cycle response pulse. An ACCESS-phase watchdog aborts stuck slaves.
module apb_master_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    pclk,
  input  logic                    preset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  input  logic [2:0]              cmd_prot,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic [2:0]              pprot,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  input  logic                    pready,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pslverr
);

  localparam int SW = DATA_WIDTH / 8;
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] wd_cnt;
  logic          accept, done, abort, wd_hit;

  // Hit means this low-pready cycle is the one that brings the count to the limit.
  assign wd_hit = (TIMEOUT_CYCLES != 0) && (wd_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge pclk) begin
    if (preset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    psel      = 1'b0;
    penable   = 1'b0;
    accept    = 1'b0;
    done      = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          accept    = 1'b1;
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        psel      = 1'b1;
        state_nxt = ACCESS;
      end
      ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        // pready takes priority over a watchdog hit on the same edge
        if (pready) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else if (wd_hit) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      paddr       <= '0;
      pprot       <= '0;
      pwrite      <= 1'b0;
      pwdata      <= '0;
      pstrb       <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      wd_cnt      <= '0;
    end else begin
      rsp_valid   <= done | abort;
      rsp_err     <= (done & pslverr) | abort;
      rsp_timeout <= abort;
      rsp_rdata   <= (done && !pwrite) ? prdata : '0;

      if (accept) begin
        paddr  <= cmd_addr;
        pprot  <= cmd_prot;
        pwrite <= cmd_write;
        pwdata <= cmd_write ? cmd_wdata : '0;
        pstrb  <= cmd_write ? cmd_strb : SW'(0);
      end else if (done || abort) begin
        paddr  <= '0;
        pprot  <= '0;
        pwrite <= 1'b0;
        pwdata <= '0;
        pstrb  <= '0;
      end

      if (state == SETUP)
        wd_cnt <= '0;
      else if (state == ACCESS && !pready && TIMEOUT_CYCLES != 0)
        wd_cnt <= wd_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: table vectors, hand-written corner sequences and
// randomized transfers checked against a memory-level reference model.
module tb_apb_master_bridge;

  localparam int TO = 16;

  logic        pclk, preset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_strb;
  logic [2:0]  cmd_prot;
  logic        rsp_valid, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [31:0] paddr, pwdata, prdata;
  logic [2:0]  pprot;
  logic        psel, penable, pwrite, pready, pslverr;
  logic [3:0]  pstrb;

  apb_master_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .paddr(paddr), .pprot(pprot), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pstrb(pstrb), .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Bench slave: 64-word memory, programmable wait states, error injection.
  logic [31:0] smem [0:63];
  int          sl_waits, acc_cnt;
  bit          sl_err;

  assign pready  = psel && penable && (acc_cnt == sl_waits);
  assign pslverr = pready && sl_err;
  assign prdata  = smem[paddr[7:2]];

  always @(posedge pclk) begin
    if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
    else                            acc_cnt <= 0;
    if (psel && penable && pready && pwrite && !pslverr)
      for (int b = 0; b < 4; b++)
        if (pstrb[b]) smem[paddr[7:2]][8*b +: 8] <= pwdata[8*b +: 8];
  end

  int n_chk, n_fail;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    bit          write;
    logic [31:0] addr, wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    int          waits;
    bit          err;
    logic [31:0] exp_rdata;
    bit          exp_err, exp_to;
    int          exp_lat;
  } vec_t;

  function automatic vec_t mk(bit w, logic [31:0] a, logic [31:0] d, logic [3:0] s,
                              int waits, bit err, logic [31:0] er, bit ee, bit et, int el);
    vec_t v;
    v.write = w; v.addr = a; v.wdata = d; v.strb = s; v.prot = 3'b010;
    v.waits = waits; v.err = err;
    v.exp_rdata = er; v.exp_err = ee; v.exp_to = et; v.exp_lat = el;
    return v;
  endfunction

  // Reference model: word memory; a transfer commits only if the slave answers without error.
  logic [31:0] ref_mem [0:63];

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic vec_t predict(vec_t v);
    vec_t r;
    bit   to;
    r = v;
    to = (v.waits >= TO);
    r.exp_lat   = to ? 2 + TO : 3 + v.waits;
    r.exp_to    = to;
    r.exp_err   = to || v.err;
    r.exp_rdata = (!v.write && !to) ? ref_mem[v.addr[7:2]] : 32'h0;
    return r;
  endfunction

  task automatic ref_update(input vec_t v);
    if (v.write && !v.err && v.waits < TO)
      ref_mem[v.addr[7:2]] = merge(ref_mem[v.addr[7:2]], v.wdata, v.strb);
  endtask

  // One complete transfer with protocol and response checks.
  task automatic xfer(input vec_t v, input string tag);
    int  k, lat, nsel, nen, nlo;
    bit  got, stable;
    @(negedge pclk);
    sl_waits = v.waits; sl_err = v.err;
    cmd_write = v.write; cmd_addr = v.addr; cmd_wdata = v.wdata;
    cmd_strb = v.strb; cmd_prot = v.prot; cmd_valid = 1'b1;
    k = 0;
    while (!cmd_ready && k < 50) begin @(negedge pclk); k++; end
    chk({tag, " ready_before_accept"}, {31'b0, cmd_ready}, 32'd1);
    @(posedge pclk); #1 cmd_valid = 1'b0;
    got = 0; lat = 0; nsel = 0; nen = 0; nlo = 0; stable = 1;
    for (int c = 1; c <= 40 && !got; c++) begin
      @(negedge pclk);
      if (rsp_valid) begin
        got = 1; lat = c;
      end else begin
        if (psel) nsel++;
        if (penable) nen++;
        if (!cmd_ready) nlo++;
        if (psel && (paddr !== v.addr || pwrite !== v.write || pprot !== v.prot)) stable = 0;
        if (c == 1) begin
          chk({tag, " setup_psel_penable"}, {30'b0, psel, penable}, 32'b10);
          chk({tag, " setup_pwdata"}, pwdata, v.write ? v.wdata : 32'h0);
          chk({tag, " setup_pstrb"}, {28'b0, pstrb}, v.write ? {28'b0, v.strb} : 32'h0);
        end
      end
    end
    chk({tag, " rsp_seen"}, {31'b0, got}, 32'd1);
    chk({tag, " latency"}, lat, v.exp_lat);
    chk({tag, " psel_cycles"}, nsel, v.exp_lat - 1);
    chk({tag, " penable_cycles"}, nen, v.exp_lat - 2);
    chk({tag, " ready_low_cycles"}, nlo, v.exp_lat - 1);
    chk({tag, " bus_stable"}, {31'b0, stable}, 32'd1);
    chk({tag, " rsp_rdata"}, rsp_rdata, v.exp_rdata);
    chk({tag, " rsp_err_to"}, {30'b0, rsp_err, rsp_timeout}, {30'b0, v.exp_err, v.exp_to});
    chk({tag, " idle_at_rsp"}, {30'b0, psel, cmd_ready}, 32'b01);
    @(negedge pclk);
    chk({tag, " rsp_one_cycle"}, {rsp_rdata[28:0], rsp_valid, rsp_err, rsp_timeout}, 32'h0);
  endtask

  vec_t tbl [12];
  vec_t v;

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    n_chk = 0; n_fail = 0;
    for (int i = 0; i < 64; i++) begin smem[i] = 32'h0; ref_mem[i] = 32'h0; end
    sl_waits = 0; sl_err = 0;
    preset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0; cmd_prot = '0;

    repeat (2) @(posedge pclk);
    @(negedge pclk);
    chk("reset_ctrl", {26'b0, psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout}, 32'h0);
    chk("reset_paddr", paddr, 32'h0);
    chk("reset_data", pwdata | rsp_rdata | {28'b0, pstrb} | {29'b0, pprot}, 32'h0);
    chk("reset_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    preset = 1'b0;

    tbl[0]  = mk(1, 32'h0C, 32'hDEADBEEF, 4'hF, 0,   0, 32'h0,        0, 0, 3);
    tbl[1]  = mk(0, 32'h0C, 32'h0,        4'hF, 0,   0, 32'hDEADBEEF, 0, 0, 3);
    tbl[2]  = mk(1, 32'h10, 32'h12345678, 4'hF, 0,   0, 32'h0,        0, 0, 3);
    tbl[3]  = mk(0, 32'h10, 32'h0,        4'h0, 3,   0, 32'h12345678, 0, 0, 6);
    tbl[4]  = mk(1, 32'h04, 32'h11111111, 4'hF, 0,   1, 32'h0,        1, 0, 3);
    tbl[5]  = mk(0, 32'h04, 32'h0,        4'h0, 0,   0, 32'h0,        0, 0, 3);
    tbl[6]  = mk(0, 32'h08, 32'h0,        4'h0, 100, 0, 32'h0,        1, 1, 18);
    tbl[7]  = mk(1, 32'h20, 32'hAABBCCDD, 4'h5, 0,   0, 32'h0,        0, 0, 3);
    tbl[8]  = mk(0, 32'h20, 32'h0,        4'h0, 15,  0, 32'h00BB00DD, 0, 0, 18);
    tbl[9]  = mk(0, 32'h0C, 32'h0,        4'h0, 0,   1, 32'hDEADBEEF, 1, 0, 3);
    tbl[10] = mk(1, 32'h14, 32'h55555555, 4'hF, 16,  0, 32'h0,        1, 1, 18);
    tbl[11] = mk(0, 32'h14, 32'h0,        4'h0, 0,   0, 32'h0,        0, 0, 3);
    for (int i = 0; i < 12; i++) begin
      xfer(tbl[i], $sformatf("vec%0d", i));
      ref_update(tbl[i]);
    end

    // Preload, then four reads with cmd_valid held high.
    for (int i = 0; i < 4; i++) begin
      v = mk(1, 32'h40 + 32'(4*i), 32'hA0A0_0000 + 32'(i * 17), 4'hF, 0, 0, 0, 0, 0, 0);
      v = predict(v);
      xfer(v, $sformatf("pre%0d", i));
      ref_update(v);
    end
    begin
      int acc_cyc [4];
      int rsp_cyc [4];
      int idx, nrsp, cyc;
      bit acc_now;
      idx = 0; nrsp = 0; cyc = 0;
      @(negedge pclk);
      sl_waits = 0; sl_err = 0;
      cmd_write = 1'b0; cmd_addr = 32'h40; cmd_valid = 1'b1;
      while (cyc < 40) begin
        if (rsp_valid && nrsp < 4) begin
          chk($sformatf("b2b_rdata%0d", nrsp), rsp_rdata, ref_mem[16 + nrsp]);
          rsp_cyc[nrsp] = cyc; nrsp++;
        end
        acc_now = cmd_valid && cmd_ready;
        @(posedge pclk);
        if (acc_now) begin
          acc_cyc[idx] = cyc; idx++;
          #1;
          if (idx < 4) cmd_addr = 32'h40 + 32'(4*idx);
          else         cmd_valid = 1'b0;
        end
        @(negedge pclk);
        cyc++;
      end
      chk("b2b_accepts", idx, 4);
      chk("b2b_responses", nrsp, 4);
      if (idx == 4 && nrsp == 4)
        for (int i = 1; i < 4; i++) begin
          chk($sformatf("b2b_spacing%0d", i), acc_cyc[i] - acc_cyc[i-1], 3);
          chk($sformatf("b2b_overlap%0d", i), acc_cyc[i], rsp_cyc[i-1]);
        end
    end

    // Reset in the middle of a write's ACCESS phase.
    begin
      int nrsp;
      @(negedge pclk);
      sl_waits = 5; sl_err = 0;
      cmd_write = 1'b1; cmd_addr = 32'h30; cmd_wdata = 32'hCAFEF00D;
      cmd_strb = 4'hF; cmd_valid = 1'b1;
      @(posedge pclk); #1 cmd_valid = 1'b0;
      @(negedge pclk);
      @(negedge pclk);
      chk("rst_mid_in_access", {30'b0, psel, penable}, 32'b11);
      preset = 1'b1;
      @(posedge pclk);
      @(negedge pclk);
      chk("rst_mid_bus_idle", {30'b0, psel, penable}, 32'b00);
      chk("rst_mid_paddr", paddr, 32'h0);
      preset = 1'b0;
      nrsp = 0;
      repeat (8) begin @(negedge pclk); if (rsp_valid) nrsp++; end
      chk("rst_mid_no_rsp", nrsp, 0);
      v = predict(mk(0, 32'h30, 0, 0, 0, 0, 0, 0, 0, 0));
      xfer(v, "rst_after_read");
      v = predict(mk(1, 32'h30, 32'h0BADCAFE, 4'hF, 1, 0, 0, 0, 0, 0));
      xfer(v, "rst_after_write");
      ref_update(v);
    end

    // Randomized transfers against the reference model.
    for (int i = 0; i < 40; i++) begin
      int r;
      r = $urandom_range(0, 9);
      v = mk($urandom_range(0, 1), {24'b0, 6'($urandom_range(0, 63)), 2'b00}, $urandom,
             4'($urandom_range(0, 15)), 0, ($urandom_range(0, 5) == 0), 0, 0, 0, 0);
      v.waits = (r < 7) ? r % 4 : (r == 7) ? TO - 1 : (r == 8) ? TO : TO + 4;
      v.prot  = 3'($urandom_range(0, 7));
      v = predict(v);
      xfer(v, $sformatf("rnd%0d", i));
      ref_update(v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
